// File: rtl/data_memory_burst_if.sv
// Request/response bundle between the cache refill path (master) and the
// burst memory model (slave).
interface data_memory_burst_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BURST_LEN  = 4
);
   logic                              req_valid;
   logic                              req_ready;
   logic                              req_we;
   logic [ADDR_WIDTH-1:0]             req_addr;
   logic [DATA_WIDTH*BURST_LEN-1:0]   wr_line;
   logic [DATA_WIDTH/8*BURST_LEN-1:0] wr_strb;
   logic                              rd_valid;
   logic [DATA_WIDTH-1:0]             rd_data;
   logic                              rd_last;
   logic                              wr_done;

   modport master (
      output req_valid, req_we, req_addr, wr_line, wr_strb,
      input  req_ready, rd_valid, rd_data, rd_last, wr_done
   );

   modport slave (
      input  req_valid, req_we, req_addr, wr_line, wr_strb,
      output req_ready, rd_valid, rd_data, rd_last, wr_done
   );
endinterface

// File: rtl/data_memory_burst.sv
// Latency-modelled line memory: serves BURST_LEN-beat reads (optionally
// critical-word-first) and full-line strobed writes behind a valid/ready request.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | req_ready high, waiting for a request
// RD_WAIT  | read accepted, counting up to RD_LATENCY
// RD_BURST | streaming the remaining beats of the line
// WR_WAIT  | write accepted, counting up to WR_LATENCY, then commit
module data_memory_burst #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int RAM_DEPTH  = 256,
   parameter int BURST_LEN  = 4,
   parameter int RD_LATENCY = 20,
   parameter int WR_LATENCY = 20,
   parameter int CWF        = 0
) (
   input  logic                clk,
   input  logic                reset,
   data_memory_burst_if.slave  bus
);

   localparam int BYTES   = DATA_WIDTH / 8;
   localparam int IDX_W   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
   localparam int OFF_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int BEAT_W  = $clog2(BURST_LEN + 1);
   localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int CNT_W   = $clog2(MAX_LAT + 2);
   localparam logic [IDX_W-1:0] LINE_MASK = IDX_W'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT} state_t;

   state_t                          state;
   logic [CNT_W-1:0]                cnt;
   logic [BEAT_W-1:0]               beat;
   logic [IDX_W-1:0]                base;
   logic [OFF_W-1:0]                crit;
   logic [DATA_WIDTH*BURST_LEN-1:0] line_q;
   logic [BYTES*BURST_LEN-1:0]      strb_q;
   logic [DATA_WIDTH-1:0]           ram [RAM_DEPTH];

   logic [IDX_W-1:0] req_idx;
   logic [IDX_W-1:0] req_base;
   logic [OFF_W-1:0] req_crit;
   logic [OFF_W-1:0] rd_off;
   logic [IDX_W-1:0] rd_idx;

   assign req_idx  = bus.req_addr[IDX_W-1:0];
   assign req_base = req_idx & ~LINE_MASK;
   assign req_crit = (BURST_LEN > 1) ? req_idx[OFF_W-1:0] : '0;

   generate
      if (ADDR_WIDTH > IDX_W) begin : g_addr_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^bus.req_addr[ADDR_WIDTH-1:IDX_W];
      end
   endgenerate

   // Offset wraps modulo the line so CWF bursts never leave the line.
   always_comb begin
      rd_off = beat[OFF_W-1:0];
      if (CWF != 0) rd_off = crit + beat[OFF_W-1:0];
      if (BURST_LEN == 1) rd_off = '0;
   end

   assign rd_idx        = base | IDX_W'(rd_off);
   assign bus.req_ready = (state == IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         cnt          <= '0;
         beat         <= '0;
         base         <= '0;
         crit         <= '0;
         line_q       <= '0;
         strb_q       <= '0;
         bus.rd_valid <= 1'b0;
         bus.rd_data  <= '0;
         bus.rd_last  <= 1'b0;
         bus.wr_done  <= 1'b0;
         for (int i = 0; i < RAM_DEPTH; i++) ram[i] <= DATA_WIDTH'(i);
      end else begin
         bus.wr_done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  base   <= req_base;
                  crit   <= req_crit;
                  line_q <= bus.wr_line;
                  strb_q <= bus.wr_strb;
                  cnt    <= CNT_W'(1);
                  beat   <= '0;
                  state  <= bus.req_we ? WR_WAIT : RD_WAIT;
               end
            end
            RD_WAIT: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(RD_LATENCY)) begin
                  bus.rd_data  <= ram[rd_idx];
                  bus.rd_valid <= 1'b1;
                  bus.rd_last  <= (BURST_LEN == 1);
                  beat         <= BEAT_W'(1);
                  state        <= RD_BURST;
               end
            end
            RD_BURST: begin
               if (beat < BEAT_W'(BURST_LEN)) begin
                  bus.rd_data <= ram[rd_idx];
                  bus.rd_last <= (beat == BEAT_W'(BURST_LEN - 1));
                  beat        <= beat + 1'b1;
               end else begin
                  bus.rd_valid <= 1'b0;
                  bus.rd_last  <= 1'b0;
                  state        <= IDLE;
               end
            end
            WR_WAIT: begin
               cnt <= cnt + 1'b1;
               // Commit happens only here, so a reset during the wait leaves no trace.
               if (cnt == CNT_W'(WR_LATENCY)) begin
                  for (int w = 0; w < BURST_LEN; w++) begin
                     for (int b = 0; b < BYTES; b++) begin
                        if (strb_q[w*BYTES + b])
                           ram[base | IDX_W'(w)][b*8 +: 8] <= line_q[(w*BYTES + b)*8 +: 8];
                     end
                  end
                  bus.wr_done <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_memory_burst.sv
// Drives identical request streams into an ascending-order and a
// critical-word-first instance and checks both against a line-level memory model.
module tb_data_memory_burst;

   localparam int RDL = 20;
   localparam int WRL = 20;
   localparam int BL  = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests_run = 0;
   int   tests_failed = 0;
   logic [31:0] mem [256];

   always #5 clk = ~clk;

   data_memory_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LEN(BL)) b0 ();
   data_memory_burst_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BURST_LEN(BL)) b1 ();

   data_memory_burst #(.RD_LATENCY(RDL), .WR_LATENCY(WRL), .CWF(0)) dut0 (
      .clk(clk), .reset(reset), .bus(b0));
   data_memory_burst #(.RD_LATENCY(RDL), .WR_LATENCY(WRL), .CWF(1)) dut1 (
      .clk(clk), .reset(reset), .bus(b1));

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input logic we, input logic [31:0] a,
                        input logic [127:0] l, input logic [15:0] s);
      b0.req_valid = v; b0.req_we = we; b0.req_addr = a; b0.wr_line = l; b0.wr_strb = s;
      b1.req_valid = v; b1.req_we = we; b1.req_addr = a; b1.wr_line = l; b1.wr_strb = s;
   endtask

   task automatic model_init();
      for (int i = 0; i < 256; i++) mem[i] = 32'(i);
   endtask

   // Called at a negedge with the DUTs idle; returns at the negedge after req_ready rises.
   task automatic do_read(input logic [31:0] addr, input bit hold, input string tag);
      logic [31:0] e0 [BL];
      logic [31:0] e1 [BL];
      logic [3:0]  want;
      int idx, base, crit, k;
      idx  = int'(addr % 256);
      base = idx - idx % BL;
      crit = idx % BL;
      for (int j = 0; j < BL; j++) begin
         e0[j] = mem[base + j];
         e1[j] = mem[base + (crit + j) % BL];
      end
      drive(1'b1, 1'b0, addr, {4{$urandom}}, 16'(~0));
      for (int e = 0; e <= RDL + BL; e++) begin
         @(negedge clk);
         k = e - RDL;
         want = {e == RDL + BL, k >= 0 && k < BL, k == BL - 1, 1'b0};
         tests_run++;
         if ({b0.req_ready, b0.rd_valid, b0.rd_last, b0.wr_done} !== want) begin
            tests_failed++;
            $display("FAIL %s ctl0 e=%0d got %b want %b", tag, e,
                     {b0.req_ready, b0.rd_valid, b0.rd_last, b0.wr_done}, want);
         end
         tests_run++;
         if ({b1.req_ready, b1.rd_valid, b1.rd_last, b1.wr_done} !== want) begin
            tests_failed++;
            $display("FAIL %s ctl1 e=%0d got %b want %b", tag, e,
                     {b1.req_ready, b1.rd_valid, b1.rd_last, b1.wr_done}, want);
         end
         if (k >= 0 && k < BL) begin
            tests_run++;
            if (b0.rd_data !== e0[k]) begin
               tests_failed++;
               $display("FAIL %s data0 beat=%0d got %h want %h", tag, k, b0.rd_data, e0[k]);
            end
            tests_run++;
            if (b1.rd_data !== e1[k]) begin
               tests_failed++;
               $display("FAIL %s data1 beat=%0d got %h want %h", tag, k, b1.rd_data, e1[k]);
            end
         end
         if (!hold || e >= RDL + BL - 1) drive(1'b0, 1'b0, 32'h0, '0, '0);
         else drive(1'b1, 1'b0, $urandom, '0, '0);
      end
      if (hold) begin
         for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            tests_run++;
            if ({b0.req_ready, b0.rd_valid, b1.req_ready, b1.rd_valid} !== 4'b1010) begin
               tests_failed++;
               $display("FAIL %s idle_after e=%0d got %b want 1010", tag, e,
                        {b0.req_ready, b0.rd_valid, b1.req_ready, b1.rd_valid});
            end
         end
      end
   endtask

   // Called at a negedge; returns in the wr_done cycle (a new request may be driven at once).
   task automatic do_write(input logic [31:0] addr, input logic [127:0] line,
                           input logic [15:0] strb, input string tag);
      logic [3:0] want;
      int base;
      drive(1'b1, 1'b1, addr, line, strb);
      for (int e = 0; e <= WRL; e++) begin
         @(negedge clk);
         want = (e == WRL) ? 4'b1001 : 4'b0000;
         tests_run++;
         if ({b0.req_ready, b0.rd_valid, b0.rd_last, b0.wr_done} !== want) begin
            tests_failed++;
            $display("FAIL %s wctl0 e=%0d got %b want %b", tag, e,
                     {b0.req_ready, b0.rd_valid, b0.rd_last, b0.wr_done}, want);
         end
         tests_run++;
         if ({b1.req_ready, b1.rd_valid, b1.rd_last, b1.wr_done} !== want) begin
            tests_failed++;
            $display("FAIL %s wctl1 e=%0d got %b want %b", tag, e,
                     {b1.req_ready, b1.rd_valid, b1.rd_last, b1.wr_done}, want);
         end
         if (e == 0) drive(1'b0, 1'b0, $urandom, {4{$urandom}}, 16'($urandom));
      end
      base = int'(addr % 256) / BL * BL;
      for (int w = 0; w < BL; w++)
         for (int b = 0; b < 4; b++)
            if (strb[w*4 + b]) mem[base + w][b*8 +: 8] = line[(w*4 + b)*8 +: 8];
   endtask

   task automatic test_reset();
      tests_run++;
      if ({b0.req_ready, b0.rd_valid, b0.rd_last, b0.wr_done, b0.rd_data} !== {4'b1000, 32'h0}) begin
         tests_failed++;
         $display("FAIL reset0 got %b/%h want 1000/0",
                  {b0.req_ready, b0.rd_valid, b0.rd_last, b0.wr_done}, b0.rd_data);
      end
      tests_run++;
      if ({b1.req_ready, b1.rd_valid, b1.rd_last, b1.wr_done, b1.rd_data} !== {4'b1000, 32'h0}) begin
         tests_failed++;
         $display("FAIL reset1 got %b/%h want 1000/0",
                  {b1.req_ready, b1.rd_valid, b1.rd_last, b1.wr_done}, b1.rd_data);
      end
   endtask

   task automatic test_read_init();
      do_read(32'h0A, 1'b0, "read_init");
   endtask

   task automatic test_full_write();
      do_write(32'h10, {32'hDDDD3333, 32'hCCCC2222, 32'hBBBB1111, 32'hAAAA0000}, 16'hFFFF, "wr_full");
      do_read(32'h10, 1'b0, "rd_full");
   endtask

   task automatic test_partial_strobe();
      do_write(32'h20, {32'h0, 32'h0, 32'h000000FF, 32'h0}, 16'h0010, "wr_partial");
      do_read(32'h20, 1'b0, "rd_partial");
      tests_run++;
      if (mem[8'h21] !== 32'h000000FF) begin
         tests_failed++;
         $display("FAIL partial_model got %h want 000000ff", mem[8'h21]);
      end
   endtask

   task automatic test_alias();
      do_read(32'h10A, 1'b0, "alias");
   endtask

   task automatic test_busy_ignored();
      do_read(32'h0D, 1'b1, "busy");
   endtask

   task automatic test_back_to_back();
      do_write(32'h44, {4{$urandom}}, 16'($urandom), "b2b_w1");
      do_write(32'h47, {4{$urandom}}, 16'hFFFF, "b2b_w2");
      @(negedge clk);
      do_read(32'h45, 1'b0, "b2b_rd");
   endtask

   task automatic test_zero_strobe();
      do_write(32'h0C, {4{$urandom}}, 16'h0000, "wr_zero");
      do_read(32'h0C, 1'b0, "rd_zero");
   endtask

   task automatic test_random();
      logic [31:0] a;
      for (int n = 0; n < 8; n++) begin
         a = $urandom;
         if ($urandom_range(1, 0) == 1) begin
            do_write(a, {4{$urandom}}, 16'($urandom), "rnd_w");
            @(negedge clk);
         end else begin
            do_read(a, 1'b0, "rnd_r");
         end
      end
   endtask

   task automatic test_reset_mid_write();
      drive(1'b1, 1'b1, 32'h30, {16{8'h55}}, 16'hFFFF);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, '0, '0);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      #1;
      test_reset();
      @(negedge clk);
      reset = 1'b0;
      model_init();
      do_read(32'h30, 1'b0, "rst_mid");
      do_read(32'h12, 1'b0, "rst_init");
   endtask

   initial begin
      model_init();
      drive(1'b0, 1'b0, 32'h0, '0, '0);
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      test_read_init();
      test_full_write();
      test_partial_strobe();
      test_alias();
      test_busy_ignored();
      test_back_to_back();
      test_zero_strobe();
      test_random();
      test_reset_mid_write();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
